subpel_pass_scheduler: RTL and testbench
========================================

# subpel_pass_scheduler

Sequencing controller for the subpixel interpolation datapath. On each `start` it drives the input mux and the FIR A/B/C lane bank through one full 8x8 block:
- a horizontal pass over the 15 integer rows, then
- vertical passes over the integer, A, B and C intermediate columns.

It tracks the FIR pipeline latency to produce aligned write-back strobes for the A/B/C feedback buffers. It also reports block completion upstream.

## Interface
Parameters:
- NUM_PIXEL, 8, pixels per lane group; extended rows = NUM_PIXEL+7 = 15.
- FIR_LAT, 1, FIR register latency in cycles; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  block request; sampled only in IDLE.
- abort  in  1  cancel current block; returns to IDLE next edge, no done.
- hold  in  1  downstream stall; suppresses issue in HPASS/VPASS.
- ready  out  1  high iff state is IDLE.
- busy  out  1  high iff state is not IDLE.
- issue_valid  out  1  mux/FIR inputs are a real issue this cycle.
- issue_dir  out  1  0 = horizontal (row), 1 = vertical (column).
- issue_src  out  2  0 integer, 1 A, 2 B, 3 C feedback buffer.
- issue_idx  out  4  row (0..14) or column (0..7) index to mux.
- wb_valid  out  1  FIR outputs for an issue are valid this cycle.
- wb_dir, wb_src, wb_idx  out  1/2/4  issue_* delayed by FIR_LAT.
- done  out  1  one-cycle pulse at block completion.

## Operation
- FSM states: IDLE, HPASS, VPASS, DRAIN.
- IDLE
  - start=1 at an edge: go to HPASS, idx=0, src=0, dir=0.
  - start is ignored in every other state.
- HPASS
  - dir=0, src=0, idx 0..14.
  - After idx=14 issues: go to VPASS, idx=0, src=0, dir=1.
- VPASS
  - dir=1; src steps 0,1,2,3; idx 0..7 within each src (32 issues).
  - After src=3, idx=7 issues: go to DRAIN.
- DRAIN
  - Waits until the last issue's write-back has been presented.
  - Then asserts done for one cycle and returns to IDLE.
- issue_valid = (HPASS or VPASS) and not hold; it is combinational from state and hold. Counters advance only on edges where issue_valid=1.
- issue_dir/src/idx are registered state. They hold steady while hold=1.
- Write-back pipeline:
  - FIR_LAT-deep shift register of {issue_valid, dir, src, idx}.
  - It always shifts, because the FIR lanes have no enable; hold never stalls in-flight results.
- Ordering guarantee: the first VPASS src=1 issue comes ≥8 issues after the last HPASS issue. Every A/B/C row is therefore written back before it is read, given FIR_LAT ≤ 8.
- abort=1 in any non-IDLE state:
  - next edge → IDLE, write-back pipeline cleared (wb_valid=0), no done.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Simultaneous hold and abort: abort wins.

## Timing
- Reset values:
  - state IDLE: ready=1, busy=0.
  - issue_valid=0, issue_dir=0, issue_src=0, issue_idx=0.
  - wb_valid=0, wb_dir=0, wb_src=0, wb_idx=0.
  - done=0.
- Reset asserted mid-block: outputs take reset values asynchronously; pending write-backs are discarded.
- start accepted at edge T, hold never asserted:
  - issue k (0..46) is in cycle T+1+k.
  - HPASS occupies cycles T+1..T+15; VPASS occupies T+16..T+47.
  - The wb for issue k is in cycle T+1+k+FIR_LAT.
  - The last wb is in T+47+FIR_LAT.
  - done=1 and ready=1 in cycle T+48+FIR_LAT.
  - A start sampled at the end of that cycle is accepted (back-to-back blocks).
- Each cycle of hold=1 during HPASS/VPASS adds exactly one cycle to all later issue, wb and done times.
- Hold during DRAIN has no effect.
- wb_* fields equal the issue_* fields of FIR_LAT cycles earlier, bit-exact. wb_valid=0 marks bubbles.
- idx wraps only by explicit FSM reload (14→0 on H→V, 7→0 per src). Counters never roll over freely.

## Test plan
- Basic block, FIR_LAT=1, start at edge 0:
  - 47 issues in order H0..H14, V(src0,0..7) … V(src3,0..7).
  - wb mirrors each issue 1 cycle later; done in cycle 49 only.
- Hold for cycles 5–7 and 20:
  - issue_valid=0 on those cycles; indices frozen.
  - done delayed to cycle 53; wb sequence still complete and ordered.
- FIR_LAT=8:
  - The last H wb (H14) occurs in cycle 23, before the first V src=1 issue in cycle 24.
  - done in cycle 56.
- abort in cycle 30 (VPASS src1):
  - ready=1 in cycle 31, wb_valid=0 from cycle 31, done never pulses.
  - A subsequent start restarts at H0.
- Reset asserted asynchronously mid-HPASS (between edges): all outputs at reset values immediately.
- start held high continuously: blocks run back-to-back; each done is one cycle; start while busy is ignored.

Source files
------------

// File: rtl/subpel_pass_scheduler.sv
// Issue sequencer for the subpixel FIR bank: one horizontal pass over the
// extended rows, then vertical passes over integer/A/B/C columns.
module subpel_pass_scheduler #(
    parameter int NUM_PIXEL = 8,
    parameter int FIR_LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    output logic       ready,
    output logic       busy,
    output logic       issue_valid,
    output logic       issue_dir,
    output logic [1:0] issue_src,
    output logic [3:0] issue_idx,
    output logic       wb_valid,
    output logic       wb_dir,
    output logic [1:0] wb_src,
    output logic [3:0] wb_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        HPASS,
        VPASS,
        DRAIN
    } state_t;

    localparam logic [3:0] H_LAST     = 4'(NUM_PIXEL + 6);
    localparam logic [3:0] V_LAST     = 4'(NUM_PIXEL - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(FIR_LAT - 1);

    state_t     state;
    logic [2:0] drain_cnt;
    logic       kill;
    logic [7:0] pipe [FIR_LAT];

    assign ready       = (state == IDLE);
    assign busy        = ~ready;
    assign issue_valid = ((state == HPASS) || (state == VPASS)) && !hold;
    assign kill        = abort && busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            issue_dir <= 1'b0;
            issue_src <= 2'd0;
            issue_idx <= 4'd0;
            drain_cnt <= 3'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state     <= IDLE;
                issue_dir <= 1'b0;
                issue_src <= 2'd0;
                issue_idx <= 4'd0;
                drain_cnt <= 3'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= HPASS;
                            issue_dir <= 1'b0;
                            issue_src <= 2'd0;
                            issue_idx <= 4'd0;
                        end
                    end
                    HPASS: begin
                        if (issue_valid) begin
                            if (issue_idx == H_LAST) begin
                                state     <= VPASS;
                                issue_dir <= 1'b1;
                                issue_idx <= 4'd0;
                            end else begin
                                issue_idx <= issue_idx + 4'd1;
                            end
                        end
                    end
                    VPASS: begin
                        if (issue_valid) begin
                            if (issue_idx == V_LAST) begin
                                issue_idx <= 4'd0;
                                if (issue_src == 2'd3) begin
                                    state     <= DRAIN;
                                    issue_dir <= 1'b0;
                                    issue_src <= 2'd0;
                                    drain_cnt <= DRAIN_INIT;
                                end else begin
                                    issue_src <= issue_src + 2'd1;
                                end
                            end else begin
                                issue_idx <= issue_idx + 4'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        // Leave once the final write-back is on the outputs.
                        if (drain_cnt == 3'd0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // FIR lanes have no enable, so this shifts every cycle regardless of hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIR_LAT; i++) pipe[i] <= 8'd0;
        end else if (kill) begin
            for (int i = 0; i < FIR_LAT; i++) pipe[i] <= 8'd0;
        end else begin
            pipe[0] <= {issue_valid, issue_dir, issue_src, issue_idx};
            for (int i = 1; i < FIR_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {wb_valid, wb_dir, wb_src, wb_idx} = pipe[FIR_LAT-1];

endmodule

// File: tb/tb_subpel_pass_scheduler.sv
// Scoreboard bench for subpel_pass_scheduler at FIR_LAT=1 and FIR_LAT=8.
module tb_subpel_pass_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic hold = 1'b0;

    logic r1, b1, i1v, i1d, w1v, w1d, d1;
    logic [1:0] i1s, w1s;
    logic [3:0] i1x, w1x;
    logic r8, b8, i8v, i8d, w8v, w8d, d8;
    logic [1:0] i8s, w8s;
    logic [3:0] i8x, w8x;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int base = 0;
    int hwb8 = -1;
    int vs1 = -1;

    logic [6:0] iq1[$], wq1[$], iq8[$], wq8[$];
    int dq1[$], dq8[$];

    subpel_pass_scheduler #(.NUM_PIXEL(8), .FIR_LAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .hold(hold), .ready(r1), .busy(b1), .issue_valid(i1v),
        .issue_dir(i1d), .issue_src(i1s), .issue_idx(i1x),
        .wb_valid(w1v), .wb_dir(w1d), .wb_src(w1s), .wb_idx(w1x),
        .done(d1)
    );

    subpel_pass_scheduler #(.NUM_PIXEL(8), .FIR_LAT(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .hold(hold), .ready(r8), .busy(b8), .issue_valid(i8v),
        .issue_dir(i8d), .issue_src(i8s), .issue_idx(i8x),
        .wb_valid(w8v), .wb_dir(w8d), .wb_src(w8s), .wb_idx(w8x),
        .done(d8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_issue(input int k);
        int v;
        if (k < 15) return {1'b0, 2'd0, 4'(k)};
        v = k - 15;
        return {1'b1, 2'(v / 8), 4'(v % 8)};
    endfunction

    task automatic push_block();
        for (int k = 0; k < 47; k++) begin
            iq1.push_back(exp_issue(k));
            wq1.push_back(exp_issue(k));
            iq8.push_back(exp_issue(k));
            wq8.push_back(exp_issue(k));
        end
    endtask

    task automatic clear_q();
        iq1.delete(); wq1.delete(); iq8.delete(); wq8.delete();
        dq1.delete(); dq8.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_1"}, {r1, b1, i1v, i1d, i1s, i1x, w1v, w1d, w1s, w1x, d1},
            32'h40000);
        chk({tag, "_8"}, {r8, b8, i8v, i8d, i8s, i8x, w8v, w8d, w8s, w8x, d8},
            32'h40000);
    endtask

    always @(negedge clk) begin
        int rel;
        logic [6:0] e;
        if (!reset) begin
            rel = edge_cnt - base + 1;
            if (i1v) begin
                if (iq1.size() == 0) chk("iss1_extra", iq1.size(), 1);
                else begin e = iq1.pop_front(); chk("iss1", {i1d, i1s, i1x}, e); end
            end
            if (w1v) begin
                if (wq1.size() == 0) chk("wb1_extra", wq1.size(), 1);
                else begin e = wq1.pop_front(); chk("wb1", {w1d, w1s, w1x}, e); end
            end
            if (i8v) begin
                if (iq8.size() == 0) chk("iss8_extra", iq8.size(), 1);
                else begin e = iq8.pop_front(); chk("iss8", {i8d, i8s, i8x}, e); end
                if ({i8d, i8s, i8x} == 7'h50 && vs1 < 0) vs1 = rel;
            end
            if (w8v) begin
                if (wq8.size() == 0) chk("wb8_extra", wq8.size(), 1);
                else begin e = wq8.pop_front(); chk("wb8", {w8d, w8s, w8x}, e); end
                if ({w8d, w8s, w8x} == 7'h0e) hwb8 = rel;
            end
            if (d1) begin dq1.push_back(rel); chk("done1_ready", r1, 1); end
            if (d8) begin dq8.push_back(rel); chk("done8_ready", r8, 1); end
        end
    end

    task automatic run_block(input int ncyc, input bit hold_on,
                             input int abort_at);
        push_block();
        dq1.delete(); dq8.delete();
        hwb8 = -1; vs1 = -1;
        start = 1'b1;
        base = edge_cnt + 1;
        step();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            hold = hold_on && (c inside {[5:7], 20});
            abort = (c == abort_at);
            #1;
            if (hold_on && (c == 5 || c == 7)) begin
                chk("hold_h_1", {i1v, i1d, i1s, i1x}, {1'b0, 7'h04});
                chk("hold_h_8", {i8v, i8d, i8s, i8x}, {1'b0, 7'h04});
            end
            if (hold_on && c == 20)
                chk("hold_v_1", {i1v, i1d, i1s, i1x}, {1'b0, 7'h41});
            if (c == abort_at + 1) begin
                chk_idle("abort_idle");
                chk("abort_iq1", iq1.size(), 17);
                chk("abort_wq1", wq1.size(), 18);
                chk("abort_iq8", iq8.size(), 17);
                chk("abort_wq8", wq8.size(), 25);
                iq1.delete(); wq1.delete(); iq8.delete(); wq8.delete();
            end
            step();
        end
        hold = 1'b0;
        abort = 1'b0;
    endtask

    task automatic end_block(input string tag, input int exp1, input int exp8);
        chk({tag, "_q_empty"}, iq1.size() + wq1.size() + iq8.size() + wq8.size(), 0);
        chk({tag, "_ndone1"}, dq1.size(), 1);
        chk({tag, "_ndone8"}, dq8.size(), 1);
        chk({tag, "_done1_at"}, dq1.size() > 0 ? dq1[0] : -1, exp1);
        chk({tag, "_done8_at"}, dq8.size() > 0 ? dq8[0] : -1, exp8);
    endtask

    initial begin
        repeat (3) step();
        chk_idle("rst_in");
        reset = 1'b0;
        step();
        chk_idle("rst_out");

        run_block(62, 1'b0, -1);
        end_block("basic", 49, 56);
        chk("h14_wb8_at", hwb8, 23);
        chk("v_src1_iss8_at", vs1, 24);

        run_block(66, 1'b1, -1);
        end_block("hold", 53, 60);

        run_block(60, 1'b0, 30);
        chk("abort_nodone1", dq1.size(), 0);
        chk("abort_nodone8", dq8.size(), 0);

        run_block(62, 1'b0, -1);
        end_block("restart", 49, 56);

        push_block();
        start = 1'b1;
        base = edge_cnt + 1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_rst_idx", {i1v, i1x}, {1'b1, 4'd4});
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_rst");
        step();
        reset = 1'b0;
        clear_q();
        step();
        chk_idle("post_rst");

        push_block(); push_block(); push_block();
        start = 1'b1;
        base = edge_cnt + 1;
        for (int c = 0; c <= 180; c++) begin
            if (c == 120) start = 1'b0;
            step();
        end
        chk("b2b_q_empty", iq1.size() + wq1.size() + iq8.size() + wq8.size(), 0);
        chk("b2b_ndone1", dq1.size(), 3);
        chk("b2b_ndone8", dq8.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_done1_at", dq1.size() > i ? dq1[i] : -1, 49 * (i + 1));
            chk("b2b_done8_at", dq8.size() > i ? dq8[i] : -1, 56 * (i + 1));
        end
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
